pipe_control: RTL and testbench

Pipelined control unit for the five-stage core. Decodes the ID-stage instruction into the standard control bundle, registers it into the ID/EX boundary, and owns load-use hazard stalling and redirect flushing. A parameter sets how many bubbles a load-use hazard costs, so one block serves both forwarding and non-forwarding memory paths. Sits between the IF/ID register and the EX stage. The PC and IF/ID hold logic consume `stall_o`.

---
 rtl/pipe_control_pkg.sv | 89 ++++++++
 rtl/ctrl_decode.sv | 115 +++++++++++
 rtl/pipe_control.sv | 102 ++++++++++
 tb/tb_pipe_control.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_control_pkg.sv
// Shared encodings and the ID/EX control bundle for the pipelined control unit.
// Decoder and hazard logic both import this package.
package pipe_control_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STYPE = 7'b0100011;
    localparam logic [6:0] OP_BTYPE = 7'b1100011;
    localparam logic [6:0] OP_JTYPE = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_PASS = 4'd10
    } alu_e;

    typedef enum logic [1:0] {
        WB_MEM = 2'd0,
        WB_ALU = 2'd1,
        WB_PC  = 2'd2
    } wb_e;

    // RUN/STALL is implied by the bubble counter; this names it.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       pcsel;
        logic       immsel;
        logic       regwren;
        logic       rs1sel;
        logic       rs2sel;
        logic       memren;
        logic       memwren;
        wb_e        wbsel;
        alu_e       alusel;
        logic [4:0] rd;
        logic [2:0] funct3;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        valid:   1'b0,
        illegal: 1'b0,
        pcsel:   1'b0,
        immsel:  1'b0,
        regwren: 1'b0,
        rs1sel:  1'b0,
        rs2sel:  1'b0,
        memren:  1'b0,
        memwren: 1'b0,
        wbsel:   WB_ALU,
        alusel:  ALU_ADD,
        rd:      5'd0,
        funct3:  3'd0
    };

    // alt is funct7[5] already qualified by the caller for the instruction type.
    function automatic alu_e alu_op(input logic [2:0] funct3, input logic alt);
        alu_e res;
        case (funct3)
            3'b000:  res = alt ? ALU_SUB : ALU_ADD;
            3'b001:  res = ALU_SLL;
            3'b010:  res = ALU_SLT;
            3'b011:  res = ALU_SLTU;
            3'b100:  res = ALU_XOR;
            3'b101:  res = alt ? ALU_SRA : ALU_SRL;
            3'b110:  res = ALU_OR;
            default: res = ALU_AND;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: opcode to control bundle plus the
// register-use flags consumed by load-use hazard detection.
module ctrl_decode
    import pipe_control_pkg::*;
(
    input  logic [31:0] insn,
    output ctrl_t       ctrl,
    output logic        use_rs1,
    output logic        use_rs2,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [4:0] rd;
    logic       alt;
    logic       unused_bits;

    assign opcode      = insn[6:0];
    assign rd          = insn[11:7];
    assign f3          = insn[14:12];
    assign rs1         = insn[19:15];
    assign rs2         = insn[24:20];
    assign alt         = insn[30];
    assign unused_bits = ^{insn[31], insn[29:25]};

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        ctrl    = CTRL_BUBBLE;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.regwren = 1'b1;
                ctrl.alusel  = alu_op(f3, alt);
                ctrl.rd      = rd;
                ctrl.funct3  = f3;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OP_ITYPE: begin
                ctrl.regwren = 1'b1;
                ctrl.immsel  = 1'b1;
                ctrl.rs2sel  = 1'b1;
                // funct7[5] is immediate data except on the shift-right encodings.
                ctrl.alusel  = alu_op(f3, alt && (f3 == 3'b101));
                ctrl.rd      = rd;
                ctrl.funct3  = f3;
                use_rs1      = 1'b1;
            end
            OP_LOAD: begin
                ctrl.regwren = 1'b1;
                ctrl.immsel  = 1'b1;
                ctrl.rs2sel  = 1'b1;
                ctrl.memren  = 1'b1;
                ctrl.wbsel   = WB_MEM;
                ctrl.rd      = rd;
                ctrl.funct3  = f3;
                use_rs1      = 1'b1;
            end
            OP_STYPE: begin
                ctrl.immsel  = 1'b1;
                ctrl.rs2sel  = 1'b1;
                ctrl.memwren = 1'b1;
                ctrl.funct3  = f3;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OP_BTYPE: begin
                ctrl.immsel  = 1'b1;
                ctrl.rs1sel  = 1'b1;
                ctrl.rs2sel  = 1'b1;
                ctrl.funct3  = f3;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OP_JTYPE: begin
                ctrl.pcsel   = 1'b1;
                ctrl.immsel  = 1'b1;
                ctrl.regwren = 1'b1;
                ctrl.rs1sel  = 1'b1;
                ctrl.rs2sel  = 1'b1;
                ctrl.wbsel   = WB_PC;
                ctrl.rd      = rd;
            end
            OP_JALR: begin
                ctrl.pcsel   = 1'b1;
                ctrl.immsel  = 1'b1;
                ctrl.regwren = 1'b1;
                ctrl.rs2sel  = 1'b1;
                ctrl.wbsel   = WB_PC;
                ctrl.rd      = rd;
                ctrl.funct3  = f3;
                use_rs1      = 1'b1;
            end
            OP_LUI: begin
                ctrl.regwren = 1'b1;
                ctrl.immsel  = 1'b1;
                ctrl.rs2sel  = 1'b1;
                ctrl.alusel  = ALU_PASS;
                ctrl.rd      = rd;
            end
            OP_AUIPC: begin
                ctrl.regwren = 1'b1;
                ctrl.immsel  = 1'b1;
                ctrl.rs1sel  = 1'b1;
                ctrl.rs2sel  = 1'b1;
                ctrl.rd      = rd;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_control.sv
// ID/EX control register with load-use stall insertion and redirect flush.
// LU_STALL (1..3) sets the bubbles a load-use hazard costs.
module pipe_control
    import pipe_control_pkg::*;
#(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 5,
    parameter int LU_STALL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] insn_i,
    input  logic              id_valid_i,
    input  logic              redirect_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic              ex_illegal_o,
    output logic              ex_pcsel_o,
    output logic              ex_immsel_o,
    output logic              ex_regwren_o,
    output logic              ex_rs1sel_o,
    output logic              ex_rs2sel_o,
    output logic              ex_memren_o,
    output logic              ex_memwren_o,
    output logic [1:0]        ex_wbsel_o,
    output logic [3:0]        ex_alusel_o,
    output logic [AWIDTH-1:0] ex_rd_o,
    output logic [2:0]        ex_funct3_o
);

    localparam logic [1:0] LU_LOAD = 2'(LU_STALL - 1);

    ctrl_t      dec;
    ctrl_t      ex_q;
    ctrl_t      ex_d;
    logic       use_rs1;
    logic       use_rs2;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [1:0] cnt;
    logic [1:0] cnt_d;
    logic       hz;
    state_e     state;

    ctrl_decode u_decode (
        .insn    (insn_i[31:0]),
        .ctrl    (dec),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2),
        .rs1     (rs1),
        .rs2     (rs2)
    );

    assign state = (cnt == 2'd0) ? ST_RUN : ST_STALL;

    // Only a load still in EX can create the hazard, so none is seen during STALL.
    assign hz = id_valid_i && ex_q.valid && ex_q.memren && (ex_q.rd != 5'd0)
             && ((use_rs1 && (rs1 == ex_q.rd)) || (use_rs2 && (rs2 == ex_q.rd)));

    assign stall_o = !redirect_i && (hz || (state == ST_STALL));

    always_comb begin
        ex_d  = CTRL_BUBBLE;
        cnt_d = cnt;
        if (redirect_i) begin
            cnt_d = 2'd0;
        end else if (state == ST_STALL) begin
            cnt_d = cnt - 2'd1;
        end else if (hz) begin
            cnt_d = LU_LOAD;
        end else if (id_valid_i) begin
            ex_d       = dec;
            ex_d.valid = 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= CTRL_BUBBLE;
            cnt  <= 2'd0;
        end else begin
            ex_q <= ex_d;
            cnt  <= cnt_d;
        end
    end

    assign ex_valid_o   = ex_q.valid;
    assign ex_illegal_o = ex_q.illegal;
    assign ex_pcsel_o   = ex_q.pcsel;
    assign ex_immsel_o  = ex_q.immsel;
    assign ex_regwren_o = ex_q.regwren;
    assign ex_rs1sel_o  = ex_q.rs1sel;
    assign ex_rs2sel_o  = ex_q.rs2sel;
    assign ex_memren_o  = ex_q.memren;
    assign ex_memwren_o = ex_q.memwren;
    assign ex_wbsel_o   = ex_q.wbsel;
    assign ex_alusel_o  = ex_q.alusel;
    assign ex_rd_o      = AWIDTH'(ex_q.rd);
    assign ex_funct3_o  = ex_q.funct3;

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: two lanes (LU_STALL=1 and 3) checked every cycle
// against a behavioural model, plus directed literal checks.
module tb_pipe_control;
    import pipe_control_pkg::*;

    localparam int NL = 2;
    localparam logic [31:0] ADD3  = 32'h002081B3;
    localparam logic [31:0] LW5   = 32'h0000A283;
    localparam logic [31:0] ADD6  = 32'h00128333;
    localparam logic [31:0] SW5   = 32'h00512023;
    localparam logic [31:0] LW0   = 32'h0000A003;
    localparam logic [31:0] LUI7  = 32'h000123B7;
    localparam logic [31:0] ILLEG = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] insn     [NL];
    logic        id_valid [NL];
    logic        redirect [NL];

    logic        stall      [NL];
    logic        ex_valid   [NL];
    logic        ex_illegal [NL];
    logic        ex_pcsel   [NL];
    logic        ex_immsel  [NL];
    logic        ex_regwren [NL];
    logic        ex_rs1sel  [NL];
    logic        ex_rs2sel  [NL];
    logic        ex_memren  [NL];
    logic        ex_memwren [NL];
    logic [1:0]  ex_wbsel   [NL];
    logic [3:0]  ex_alusel  [NL];
    logic [4:0]  ex_rd      [NL];
    logic [2:0]  ex_funct3  [NL];

    int    n_checks = 0;
    int    n_errors = 0;
    logic  checking = 1'b0;
    ctrl_t exp_ex [NL];
    int    bub    [NL];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        pipe_control #(
            .DWIDTH   (32),
            .AWIDTH   (5),
            .LU_STALL ((g == 0) ? 1 : 3)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .insn_i       (insn[g]),
            .id_valid_i   (id_valid[g]),
            .redirect_i   (redirect[g]),
            .stall_o      (stall[g]),
            .ex_valid_o   (ex_valid[g]),
            .ex_illegal_o (ex_illegal[g]),
            .ex_pcsel_o   (ex_pcsel[g]),
            .ex_immsel_o  (ex_immsel[g]),
            .ex_regwren_o (ex_regwren[g]),
            .ex_rs1sel_o  (ex_rs1sel[g]),
            .ex_rs2sel_o  (ex_rs2sel[g]),
            .ex_memren_o  (ex_memren[g]),
            .ex_memwren_o (ex_memwren[g]),
            .ex_wbsel_o   (ex_wbsel[g]),
            .ex_alusel_o  (ex_alusel[g]),
            .ex_rd_o      (ex_rd[g]),
            .ex_funct3_o  (ex_funct3[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic int lu_of(input int l);
        return (l == 0) ? 1 : 3;
    endfunction

    // ---------------- behavioural model ----------------
    function automatic ctrl_t ref_bubble();
        ctrl_t c;
        c        = '0;
        c.wbsel  = WB_ALU;
        c.alusel = ALU_ADD;
        return c;
    endfunction

    // Per-class flag table: {pcsel, immsel, regwren, rs1sel, rs2sel, memren, memwren}.
    function automatic ctrl_t ref_decode(input logic [31:0] w);
        ctrl_t      c;
        logic [6:0] f;
        wb_e        wb;
        logic       has_f3;
        logic       legal;
        alu_e       tab [8];
        tab    = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        c      = ref_bubble();
        f      = 7'b0;
        wb     = WB_ALU;
        has_f3 = 1'b0;
        legal  = 1'b1;
        case (w[6:0])
            7'b0110011: begin
                f = 7'b0010000; has_f3 = 1'b1; c.alusel = tab[w[14:12]];
                if (w[30] && w[14:12] == 3'd0) c.alusel = ALU_SUB;
                if (w[30] && w[14:12] == 3'd5) c.alusel = ALU_SRA;
            end
            7'b0010011: begin
                f = 7'b0110100; has_f3 = 1'b1; c.alusel = tab[w[14:12]];
                if (w[30] && w[14:12] == 3'd5) c.alusel = ALU_SRA;
            end
            7'b0000011: begin f = 7'b0110110; wb = WB_MEM; has_f3 = 1'b1; end
            7'b0100011: begin f = 7'b0100101; has_f3 = 1'b1; end
            7'b1100011: begin f = 7'b0101100; has_f3 = 1'b1; end
            7'b1101111: begin f = 7'b1111100; wb = WB_PC; end
            7'b1100111: begin f = 7'b1110100; wb = WB_PC; has_f3 = 1'b1; end
            7'b0110111: begin f = 7'b0110100; c.alusel = ALU_PASS; end
            7'b0010111: begin f = 7'b0111100; end
            default:    legal = 1'b0;
        endcase
        if (!legal) begin
            c.illegal = 1'b1;
            return c;
        end
        {c.pcsel, c.immsel, c.regwren, c.rs1sel, c.rs2sel, c.memren, c.memwren} = f;
        c.wbsel  = wb;
        c.rd     = c.regwren ? w[11:7] : 5'd0;
        c.funct3 = has_f3 ? w[14:12] : 3'd0;
        return c;
    endfunction

    // {uses rs1, uses rs2}
    function automatic logic [1:0] ref_uses(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        return {op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111},
                op inside {7'b0110011, 7'b0100011, 7'b1100011}};
    endfunction

    function automatic logic m_hz(input int l);
        logic [1:0] u;
        logic [4:0] r;
        u = ref_uses(insn[l]);
        r = exp_ex[l].rd;
        return id_valid[l] && exp_ex[l].valid && exp_ex[l].memren && (r != 5'd0)
            && ((u[1] && insn[l][19:15] == r) || (u[0] && insn[l][24:20] == r));
    endfunction

    function automatic logic m_stall(input int l);
        return !redirect[l] && (m_hz(l) || bub[l] > 0);
    endfunction

    task automatic model_advance();
        for (int l = 0; l < NL; l++) begin
            if (reset || redirect[l]) begin
                exp_ex[l] = ref_bubble();
                bub[l]    = 0;
            end else if (bub[l] > 0) begin
                exp_ex[l] = ref_bubble();
                bub[l]    = bub[l] - 1;
            end else if (m_hz(l)) begin
                exp_ex[l] = ref_bubble();
                bub[l]    = lu_of(l) - 1;
            end else if (id_valid[l]) begin
                exp_ex[l]       = ref_decode(insn[l]);
                exp_ex[l].valid = 1'b1;
            end else begin
                exp_ex[l] = ref_bubble();
            end
        end
    endtask

    function automatic logic [22:0] pack_c(input ctrl_t c);
        return {c.valid, c.illegal, c.pcsel, c.immsel, c.regwren, c.rs1sel, c.rs2sel,
                c.memren, c.memwren, c.wbsel, c.alusel, c.rd, c.funct3};
    endfunction

    function automatic logic [22:0] act_pack(input int l);
        return {ex_valid[l], ex_illegal[l], ex_pcsel[l], ex_immsel[l], ex_regwren[l],
                ex_rs1sel[l], ex_rs2sel[l], ex_memren[l], ex_memwren[l], ex_wbsel[l],
                ex_alusel[l], ex_rd[l], ex_funct3[l]};
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (checking) begin
            for (int l = 0; l < NL; l++) begin
                check($sformatf("lane%0d ex bundle", l), 32'(act_pack(l)), 32'(pack_c(exp_ex[l])));
                check($sformatf("lane%0d stall", l), 32'(stall[l]), 32'(m_stall(l)));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        model_advance();
        #2;
    endtask

    task automatic drive(input int l, input logic [31:0] w, input logic v);
        insn[l]     = w;
        id_valid[l] = v;
    endtask

    function automatic logic [31:0] rand_insn();
        logic [6:0]  ops [10];
        logic [31:0] w;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
        w        = $urandom;
        w[6:0]   = ops[$urandom_range(0, 9)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic held [NL];
        reset = 1'b1;
        for (int l = 0; l < NL; l++) begin
            drive(l, ADD3, 1'b1);
            redirect[l] = 1'b0;
            exp_ex[l]   = ref_bubble();
            bub[l]      = 0;
        end

        // Reset held two cycles, then add x3 enters EX.
        cyc();
        checking = 1'b1;
        cyc();
        check("reset ex_valid", 32'(ex_valid[0]), 32'd0);
        check("reset ex_wbsel", 32'(ex_wbsel[0]), 32'(WB_ALU));
        check("reset ex_rd", 32'(ex_rd[0]), 32'd0);
        #1 check("reset stall", 32'(stall[0]), 32'd0);
        reset = 1'b0;
        cyc();
        check("add ex_valid", 32'(ex_valid[0]), 32'd1);
        check("add ex_regwren", 32'(ex_regwren[0]), 32'd1);
        check("add ex_alusel", 32'(ex_alusel[0]), 32'(ALU_ADD));
        check("add ex_rd", 32'(ex_rd[0]), 32'd3);

        // Load-use with LU_STALL=1 on lane 0.
        drive(1, 32'd0, 1'b0);
        drive(0, LW5, 1'b1);
        cyc();
        drive(0, ADD6, 1'b1);
        #1 check("lu1 stall", 32'(stall[0]), 32'd1);
        cyc();
        check("lu1 bubble", 32'(ex_valid[0]), 32'd0);
        #1 check("lu1 stall release", 32'(stall[0]), 32'd0);
        cyc();
        check("lu1 add ex_valid", 32'(ex_valid[0]), 32'd1);
        check("lu1 add ex_rd", 32'(ex_rd[0]), 32'd6);

        // Load-use with LU_STALL=3 on lane 1, hazard via rs2 of a store.
        drive(0, 32'd0, 1'b0);
        drive(1, LW5, 1'b1);
        cyc();
        drive(1, SW5, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("lu3 stall %0d", k), 32'(stall[1]), 32'd1);
            cyc();
            check($sformatf("lu3 bubble %0d", k), 32'(ex_valid[1]), 32'd0);
        end
        #1 check("lu3 stall release", 32'(stall[1]), 32'd0);
        cyc();
        check("lu3 store ex_memwren", 32'(ex_memwren[1]), 32'd1);
        check("lu3 store ex_valid", 32'(ex_valid[1]), 32'd1);

        // Load to x0 never stalls.
        drive(1, 32'd0, 1'b0);
        drive(0, LW0, 1'b1);
        cyc();
        drive(0, ADD6, 1'b1);
        #1 check("x0 no stall", 32'(stall[0]), 32'd0);
        cyc();
        check("x0 add ex_rd", 32'(ex_rd[0]), 32'd6);

        // Redirect on the second stall cycle aborts the stall.
        drive(0, 32'd0, 1'b0);
        drive(1, LW5, 1'b1);
        cyc();
        drive(1, SW5, 1'b1);
        #1 check("redir stall 1", 32'(stall[1]), 32'd1);
        cyc();
        redirect[1] = 1'b1;
        #1 check("redir stall masked", 32'(stall[1]), 32'd0);
        cyc();
        check("redir bubble", 32'(ex_valid[1]), 32'd0);
        redirect[1] = 1'b0;
        drive(1, LUI7, 1'b1);
        #1 check("redir resume stall", 32'(stall[1]), 32'd0);
        cyc();
        check("redir resume ex_rd", 32'(ex_rd[1]), 32'd7);
        check("redir resume ex_valid", 32'(ex_valid[1]), 32'd1);

        // Illegal opcode, then lui.
        drive(1, 32'd0, 1'b0);
        drive(0, ILLEG, 1'b1);
        cyc();
        check("illegal flag", 32'(ex_illegal[0]), 32'd1);
        check("illegal regwren", 32'(ex_regwren[0]), 32'd0);
        check("illegal memwren", 32'(ex_memwren[0]), 32'd0);
        drive(0, LUI7, 1'b1);
        cyc();
        check("lui ex_alusel", 32'(ex_alusel[0]), 32'(ALU_PASS));
        check("lui ex_rd", 32'(ex_rd[0]), 32'd7);

        // Randomized traffic; a stalled lane holds its ID instruction like the real front end.
        for (int i = 0; i < 2000; i++) begin
            for (int l = 0; l < NL; l++) held[l] = m_stall(l);
            cyc();
            reset = ($urandom_range(0, 199) == 0);
            for (int l = 0; l < NL; l++) begin
                if (!held[l]) drive(l, rand_insn(), ($urandom_range(0, 7) != 0));
                redirect[l] = ($urandom_range(0, 9) == 0);
            end
        end

        reset = 1'b0;
        for (int l = 0; l < NL; l++) begin
            redirect[l] = 1'b0;
            drive(l, 32'd0, 1'b0);
        end
        cyc();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
